// File: rtl/lc3_control_fsm.sv
// LC-3 fetch/decode/execute sequencer driving datapath loads, gates, mux selects and SRAM strobes.
// Optional IR pause after fetch is enabled by defining LC3_PAUSE_IR_EN.
module lc3_control_fsm #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam int unsigned STATE_W = 5;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT - 1);

    localparam logic [STATE_W-1:0] HALTED  = 5'd0;
    localparam logic [STATE_W-1:0] S18     = 5'd1;
    localparam logic [STATE_W-1:0] S33     = 5'd2;
    localparam logic [STATE_W-1:0] S35     = 5'd3;
    localparam logic [STATE_W-1:0] S32     = 5'd4;
    localparam logic [STATE_W-1:0] S01     = 5'd5;
    localparam logic [STATE_W-1:0] S05     = 5'd6;
    localparam logic [STATE_W-1:0] S09     = 5'd7;
    localparam logic [STATE_W-1:0] S00     = 5'd8;
    localparam logic [STATE_W-1:0] S22     = 5'd9;
    localparam logic [STATE_W-1:0] S12     = 5'd10;
    localparam logic [STATE_W-1:0] S04     = 5'd11;
    localparam logic [STATE_W-1:0] S21     = 5'd12;
    localparam logic [STATE_W-1:0] S20     = 5'd13;
    localparam logic [STATE_W-1:0] S06     = 5'd14;
    localparam logic [STATE_W-1:0] S25     = 5'd15;
    localparam logic [STATE_W-1:0] S27     = 5'd16;
    localparam logic [STATE_W-1:0] S07     = 5'd17;
    localparam logic [STATE_W-1:0] S23     = 5'd18;
    localparam logic [STATE_W-1:0] S16     = 5'd19;
    localparam logic [STATE_W-1:0] SPAUSE1 = 5'd20;
    localparam logic [STATE_W-1:0] SPAUSE2 = 5'd21;
`ifdef LC3_PAUSE_IR_EN
    localparam logic [STATE_W-1:0] PAUSE_IR1 = 5'd22;
    localparam logic [STATE_W-1:0] PAUSE_IR2 = 5'd23;
`endif

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_nx;
    logic               in_wait;
    logic               wait_last;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // Counter runs only inside a strobe state and is zero on entry and after exit.
    always_comb begin
        in_wait     = (state == S33) || (state == S25) || (state == S16);
        wait_last   = (wait_cnt == WAIT_LAST);
        wait_cnt_nx = '0;
        if (in_wait && !wait_last) begin
            wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx   = state;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state)
            HALTED: begin
                if (Run) state_nx = S18;
            end
            S18: begin
                GatePC   = 1'b1;
                LD_MAR   = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_nx = S33;
            end
            S33: begin
                Mem_OE = 1'b1;
                if (wait_last) begin
                    LD_MDR   = 1'b1;
                    state_nx = S35;
                end
            end
            S35: begin
                GateMDR  = 1'b1;
                LD_IR    = 1'b1;
`ifdef LC3_PAUSE_IR_EN
                state_nx = PAUSE_IR1;
`else
                state_nx = S32;
`endif
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   state_nx = S01;
                    OP_AND:   state_nx = S05;
                    OP_NOT:   state_nx = S09;
                    OP_BR:    state_nx = S00;
                    OP_JMP:   state_nx = S12;
                    OP_JSR:   state_nx = S04;
                    OP_LDR:   state_nx = S06;
                    OP_STR:   state_nx = S07;
                    OP_PAUSE: state_nx = SPAUSE1;
                    default:  state_nx = S18;
                endcase
            end
            S01, S05, S09: begin
                SR2MUX   = (state == S09) ? 1'b0 : IR_5;
                ALUK     = (state == S01) ? 2'b00 : ((state == S05) ? 2'b01 : 2'b10);
                GateALU  = 1'b1;
                LD_REG   = 1'b1;
                LD_CC    = 1'b1;
                state_nx = S18;
            end
            S00: begin
                state_nx = BEN ? S22 : S18;
            end
            S22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
                state_nx = S18;
            end
            S12, S20: begin
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
                state_nx = S18;
            end
            S04: begin
                DRMUX    = 1'b1;
                GatePC   = 1'b1;
                LD_REG   = 1'b1;
                state_nx = IR_11 ? S21 : S20;
            end
            S21: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
                state_nx = S18;
            end
            // Base register + offset6 onto the bus into MAR for both loads and stores.
            S06, S07: begin
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_nx   = (state == S06) ? S25 : S23;
            end
            S25: begin
                Mem_OE = 1'b1;
                if (wait_last) begin
                    LD_MDR   = 1'b1;
                    state_nx = S27;
                end
            end
            S27: begin
                GateMDR  = 1'b1;
                LD_REG   = 1'b1;
                LD_CC    = 1'b1;
                state_nx = S18;
            end
            S23: begin
                SR1MUX   = 1'b1;
                ALUK     = 2'b11;
                GateALU  = 1'b1;
                LD_MDR   = 1'b1;
                state_nx = S16;
            end
            S16: begin
                Mem_WE = 1'b1;
                if (wait_last) state_nx = S18;
            end
            SPAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) state_nx = SPAUSE2;
            end
            SPAUSE2: begin
                if (!Continue) state_nx = S18;
            end
`ifdef LC3_PAUSE_IR_EN
            // Post-fetch inspection stop; resumes with the next fetch, never decodes.
            PAUSE_IR1: begin
                if (Continue) state_nx = PAUSE_IR2;
            end
            PAUSE_IR2: begin
                if (!Continue) state_nx = S18;
            end
`endif
            default: begin
                state_nx = HALTED;
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Scoreboard bench for lc3_control_fsm: per-cycle expected control vectors queued per instruction.
module tb_lc3_control_fsm;

    localparam int unsigned W = 3;

    localparam int B_S00 = 0,  B_S01 = 1,  B_S04 = 4,  B_S05 = 5,  B_S06 = 6,  B_S07 = 7;
    localparam int B_S09 = 9,  B_S12 = 12, B_S16 = 16, B_S18 = 18, B_S20 = 20, B_S21 = 21;
    localparam int B_S22 = 22, B_S23 = 23, B_S25 = 25, B_S27 = 27, B_S32 = 32, B_S33 = 33;
    localparam int B_S35 = 35, B_HALT = 100, B_SP1 = 101, B_SP2 = 102, B_PIR1 = 103, B_PIR2 = 104;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mem_oe, mem_we;
    } ctl_t;

    logic Clk = 1'b0;
    logic Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

    ctl_t obs;
    ctl_t exp_q[$];
    string name_q[$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    lc3_control_fsm #(.MEM_WAIT(W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                  ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

    // Expected control word for one cycle of a named datapath step.
    function automatic ctl_t exp_ctl(input int st, input bit last, input bit ir5);
        ctl_t c;
        c = '0;
        case (st)
            B_S18: begin c.gate_pc = 1; c.ld_mar = 1; c.pcmux = 2'b10; c.ld_pc = 1; end
            B_S33, B_S25: begin c.mem_oe = 1; c.ld_mdr = last; end
            B_S35: begin c.gate_mdr = 1; c.ld_ir = 1; end
            B_S32: c.ld_ben = 1;
            B_S01: begin c.sr2mux = ir5; c.aluk = 2'b00; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
            B_S05: begin c.sr2mux = ir5; c.aluk = 2'b01; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
            B_S09: begin c.aluk = 2'b10; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
            B_S22: begin c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1; end
            B_S12, B_S20: begin c.addr1mux = 1; c.pcmux = 2'b01; c.ld_pc = 1; end
            B_S04: begin c.drmux = 1; c.gate_pc = 1; c.ld_reg = 1; end
            B_S21: begin c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; end
            B_S06, B_S07: begin c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; end
            B_S27: begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
            B_S23: begin c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; end
            B_S16: c.mem_we = 1;
            B_SP1: c.ld_led = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push_state(input string tag, input int st, input bit ir5, input int reps);
        int n;
        n = (st == B_S33 || st == B_S25 || st == B_S16) ? int'(W) : reps;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_ctl(st, (i == n - 1), ir5));
            name_q.push_back($sformatf("%s:st%0d#%0d", tag, st, i));
        end
    endtask

    // Compare the current cycle against the queue head, then move to the next cycle.
    task automatic drain();
        ctl_t e;
        string n;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, obs, e);
            end
            @(negedge Clk);
        end
    endtask

    task automatic push_fetch(input string tag);
        push_state(tag, B_S18, 0, 1);
        push_state(tag, B_S33, 0, 1);
        push_state(tag, B_S35, 0, 1);
    endtask

    task automatic restart(input string tag);
        push_state(tag, B_HALT, 0, 1);
        Run = 1'b1;
        drain();
        Run = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0001;
        IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        push_state("reset", B_HALT, 0, 3);
        drain();
        restart("reset_run");
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input bit ben,
                             input bit ir5, input bit ir11);
        Opcode = op; BEN = ben; IR_5 = ir5; IR_11 = ir11;
        push_fetch(tag);
        push_state(tag, B_S32, 0, 1);
        case (op)
            4'b0001: push_state(tag, B_S01, ir5, 1);
            4'b0101: push_state(tag, B_S05, ir5, 1);
            4'b1001: push_state(tag, B_S09, ir5, 1);
            4'b0000: begin
                push_state(tag, B_S00, 0, 1);
                if (ben) push_state(tag, B_S22, 0, 1);
            end
            4'b1100: push_state(tag, B_S12, 0, 1);
            4'b0100: begin
                push_state(tag, B_S04, 0, 1);
                push_state(tag, ir11 ? B_S21 : B_S20, 0, 1);
            end
            4'b0110: begin
                push_state(tag, B_S06, 0, 1);
                push_state(tag, B_S25, 0, 1);
                push_state(tag, B_S27, 0, 1);
            end
            4'b0111: begin
                push_state(tag, B_S07, 0, 1);
                push_state(tag, B_S23, 0, 1);
                push_state(tag, B_S16, 0, 1);
            end
            default: ;
        endcase
        drain();
    endtask

    task automatic test_alu();
        run_instr("add_reg", 4'b0001, 0, 0, 0);
        Run = 1'b1;
        run_instr("add_imm_run_hi", 4'b0001, 0, 1, 0);
        Run = 1'b0;
        run_instr("and_imm", 4'b0101, 0, 1, 0);
        run_instr("not", 4'b1001, 1, 1, 0);
        run_instr("nop", 4'b1111, 0, 0, 0);
    endtask

    task automatic test_control_flow();
        run_instr("br_nt", 4'b0000, 0, 0, 0);
        run_instr("br_t", 4'b0000, 1, 0, 0);
        run_instr("jmp", 4'b1100, 1, 0, 0);
        run_instr("jsr", 4'b0100, 0, 0, 1);
        run_instr("jsrr", 4'b0100, 0, 0, 0);
    endtask

    task automatic test_mem();
        run_instr("ldr", 4'b0110, 0, 0, 0);
        run_instr("str", 4'b0111, 0, 0, 0);
    endtask

    task automatic test_pause();
        Opcode = 4'b1101; Continue = 1'b0;
        push_fetch("pause");
        push_state("pause", B_S32, 0, 1);
        push_state("pause_hold", B_SP1, 0, 11);
        drain();
        Continue = 1'b1;
        push_state("pause_rise", B_SP1, 0, 1);
        push_state("pause_hi", B_SP2, 0, 2);
        drain();
        Continue = 1'b0;
        push_state("pause_fall", B_SP2, 0, 1);
        drain();
        // Continue already high before the pause state is reached.
        Continue = 1'b1;
        push_fetch("pause_early");
        push_state("pause_early", B_S32, 0, 1);
        push_state("pause_early", B_SP1, 0, 1);
        push_state("pause_early", B_SP2, 0, 2);
        drain();
        Continue = 1'b0;
        push_state("pause_early_fall", B_SP2, 0, 1);
        drain();
        run_instr("after_pause", 4'b0001, 0, 0, 0);
    endtask

    task automatic test_reset_mid_write();
        Opcode = 4'b0111;
        push_fetch("rst_wr");
        push_state("rst_wr", B_S32, 0, 1);
        push_state("rst_wr", B_S07, 0, 1);
        push_state("rst_wr", B_S23, 0, 1);
        exp_q.push_back(exp_ctl(B_S16, 0, 0));
        name_q.push_back("rst_wr:s16_first");
        drain();
        exp_q.push_back(exp_ctl(B_S16, 0, 0));
        name_q.push_back("rst_wr:s16_second");
        Reset = 1'b1;
        drain();
        Reset = 1'b0;
        push_state("rst_wr_halt", B_HALT, 0, 3);
        drain();
        restart("rst_wr_run");
        run_instr("rst_wr_after", 4'b0101, 0, 0, 0);
    endtask

    task automatic test_reset_in_pause();
        Opcode = 4'b1101; Continue = 1'b0;
        push_fetch("rst_p");
        push_state("rst_p", B_S32, 0, 1);
        push_state("rst_p", B_SP1, 0, 2);
        drain();
        push_state("rst_p_last", B_SP1, 0, 1);
        Reset = 1'b1;
        drain();
        Reset = 1'b0;
        push_state("rst_p_halt", B_HALT, 0, 2);
        drain();
        restart("rst_p_run");
        run_instr("rst_p_after", 4'b1100, 0, 0, 0);
    endtask

    task automatic test_pause_ir();
        Opcode = 4'b0111; Continue = 1'b0;
        push_fetch("pir");
        push_state("pir_hold", B_PIR1, 0, 4);
        drain();
        Continue = 1'b1;
        push_state("pir_rise", B_PIR1, 0, 1);
        push_state("pir_hi", B_PIR2, 0, 1);
        drain();
        Continue = 1'b0;
        push_state("pir_fall", B_PIR2, 0, 1);
        push_fetch("pir_next");
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge Clk);
        test_reset();
`ifdef LC3_PAUSE_IR_EN
        test_pause_ir();
`else
        test_alu();
        test_control_flow();
        test_mem();
        test_pause();
        test_reset_mid_write();
        test_reset_in_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
